// File: rtl/counter_ud_m.sv
// Up/down modulo counter with clamped synchronous load, enable, terminal-count flag and wrap pulse.
// Define COUNTER_SAT_EN to pin the count at its bounds instead of wrapping.
module counter_ud_m #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_C);
    assign at_zero = (count_q == '0);

    // Next-state: load beats enable; load clamps out-of-range data to MAX_VAL
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (data > MAX_C) ? MAX_C : data;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = '0;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = en & ((up & at_max) | (~up & at_zero));

endmodule
